// File: rtl/lap_core_pkg.sv
// Shared types and elaboration-time helpers for the lap_core self-check block.
package lap_core_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } lap_state_e;

  // Closed-form sum 0+1+..+(n-1), reduced modulo 2^w; n is at least 1 here.
  function automatic longint unsigned exp_sum(input longint unsigned n,
                                              input int unsigned w);
    longint unsigned s;
    s = (n * (n - 64'd1)) / 64'd2;
    if (w < 64) begin
      s = s & ((64'd1 << w) - 64'd1);
    end
    return s;
  endfunction

endpackage

// File: rtl/lap_edge_sync.sv
// Two-flop synchronizer for an asynchronous level plus a rising-edge pulse.
module lap_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic dly_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  // Delay flop clears to 0, so a level already high at reset release reads as an edge.
  assign rise = sync2_q & ~dly_q;

endmodule

// File: rtl/lap_core.sv
// Counts mclk marks, accumulates 0..NUM_TICKS-1 and raises a sticky pass flag.
module lap_core
  import lap_core_pkg::*;
#(
  parameter int unsigned NUM_TICKS = 16,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mclk,
  output logic passed
);

  localparam logic [ACC_W-1:0] EXP      = ACC_W'(exp_sum(64'(NUM_TICKS), ACC_W));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TICKS);

  logic             tick;
  lap_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             passed_q;

  lap_edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .d     (mclk),
    .rise  (tick)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        // Reaching the mark count takes priority; a coincident tick is dropped.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CHECK;
        end else if (tick) begin
          acc_d = acc_q + ACC_W'(cnt_q);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: state_d = (acc_q == EXP) ? ST_PASS : ST_FAIL;
      ST_PASS:  state_d = ST_PASS;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      acc_q    <= '0;
      cnt_q    <= '0;
      passed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      passed_q <= (state_q == ST_PASS);
    end
  end

  assign passed = passed_q;

endmodule

// File: tb/tb_lap_core.sv
// Directed-plus-random bench for lap_core against an edge-counting reference model.
module tb_lap_core;

  logic clk = 1'b0;
  logic reset;
  logic mclk;
  logic passed_a;
  logic passed_n1;
  logic passed_w4;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned edges  = 0;

  always #5 clk = ~clk;

  lap_core dut_a (
    .clk    (clk),
    .reset  (reset),
    .mclk   (mclk),
    .passed (passed_a)
  );

  lap_core #(.NUM_TICKS(1)) dut_n1 (
    .clk    (clk),
    .reset  (reset),
    .mclk   (mclk),
    .passed (passed_n1)
  );

  lap_core #(.ACC_W(4)) dut_w4 (
    .clk    (clk),
    .reset  (reset),
    .mclk   (mclk),
    .passed (passed_w4)
  );

  function automatic logic [63:0] model_acc(input int unsigned c, input int unsigned w);
    logic [63:0] s;
    s = '0;
    for (int unsigned k = 0; k < c; k++) begin
      s = s + 64'(k);
    end
    return s & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_inst(input string nm, input int unsigned n, input int unsigned w,
                          input logic [63:0] c, input logic [63:0] a, input logic [63:0] p);
    int unsigned ce;
    ce = (edges < n) ? edges : n;
    chk({nm, "_cnt"}, c, 64'(ce));
    chk({nm, "_acc"}, a, model_acc(ce, w));
    chk({nm, "_passed"}, p, (edges >= n) ? 64'd1 : 64'd0);
  endtask

  task automatic check_all();
    chk_inst("a",  16, 32, 64'(dut_a.cnt_q),  64'(dut_a.acc_q),  64'(passed_a));
    chk_inst("n1",  1, 32, 64'(dut_n1.cnt_q), 64'(dut_n1.acc_q), 64'(passed_n1));
    chk_inst("w4", 16,  4, 64'(dut_w4.cnt_q), 64'(dut_w4.acc_q), 64'(passed_w4));
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    @(negedge clk);
    mclk = 1'b1;
    repeat (hi) @(negedge clk);
    mclk = 1'b0;
    repeat (lo) @(negedge clk);
    edges++;
    repeat (4) @(negedge clk);
    check_all();
  endtask

  task automatic rand_pulse();
    pulse($urandom_range(2, 6), $urandom_range(2, 6));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    edges = 0;
    repeat (2) @(negedge clk);
    check_all();
  endtask

  // Watches the default instance's final mark: passed must lag cnt==16 by exactly 3 edges.
  task automatic pulse_watch_last();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    mclk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dut_a.cnt_q == 16'd16) begin
        seen = 1'b1;
        break;
      end
    end
    chk("lat_cnt_reached", 64'(seen), 64'd1);
    chk("lat_passed_t0", 64'(passed_a), 64'd0);
    @(negedge clk);
    chk("lat_passed_t1", 64'(passed_a), 64'd0);
    @(negedge clk);
    chk("lat_passed_t2", 64'(passed_a), 64'd0);
    @(negedge clk);
    chk("lat_passed_t3", 64'(passed_a), 64'd1);
    mclk = 1'b0;
    repeat (4) @(negedge clk);
    edges++;
    repeat (2) @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b0;
    mclk  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all();

    for (int i = 0; i < 15; i++) pulse(4, 4);
    pulse_watch_last();
    for (int i = 0; i < 20; i++) rand_pulse();

    do_reset();
    for (int i = 0; i < 8; i++) rand_pulse();
    do_reset();
    for (int i = 0; i < 16; i++) rand_pulse();

    do_reset();
    @(negedge clk);
    mclk = 1'b1;
    repeat (100) @(negedge clk);
    edges++;
    check_all();
    mclk = 1'b0;
    repeat (4) @(negedge clk);
    check_all();

    @(negedge clk);
    reset = 1'b0;
    mclk  = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    edges = 1;
    repeat (8) @(negedge clk);
    check_all();
    mclk = 1'b0;
    repeat (4) @(negedge clk);
    check_all();

    for (int r = 0; r < 3; r++) begin
      int unsigned n;
      do_reset();
      n = $urandom_range(0, 24);
      for (int unsigned i = 0; i < n; i++) rand_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
